filter_seq: RTL

FILTER_SEQ -- requirements
Module: filter_seq

---
 rtl/filter_seq.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/filter_seq.sv
// filter_seq: frame-based 9-tap FIR over 10-sample frames.
//   Samples are captured into a frame buffer; each completed frame is copied
//   into a compute buffer and reduced with a single time-shared multiplier
//   (one tap per cycle). Slot 0 of every frame is captured but never weighted.
// Ports:
//   clk         rising-edge clock
//   reset       asynchronous active-low reset
//   sig         signed input sample, qualified by sig_valid / sig_ready
//   coef_we     coefficient write strobe with coef_addr / coef_data
//   coef_err    one-cycle pulse after a rejected coefficient write
//   busy        MAC state machine is not idle
//   filter_out  signed result slice of the accumulator, held between frames
//   out_sig     one-cycle pulse while filter_out carries a fresh result
module filter_seq #(
  parameter int FRAME_LEN = 10,
  parameter int NTAPS     = 9,
  parameter int OUT_LSB   = 10,
  parameter int DATA_W    = 9,
  parameter int COEF_W    = 21,
  parameter int ACC_W     = 32,
  parameter int OUT_W     = 19
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic signed [DATA_W-1:0] sig,
  input  logic                     sig_valid,
  output logic                     sig_ready,
  input  logic                     coef_we,
  input  logic [3:0]               coef_addr,
  input  logic signed [COEF_W-1:0] coef_data,
  output logic                     coef_err,
  output logic                     busy,
  output logic signed [OUT_W-1:0]  filter_out,
  output logic                     out_sig
);

  localparam int IDX_W  = $clog2(FRAME_LEN);
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [IDX_W-1:0] LAST_SLOT = IDX_W'(FRAME_LEN - 1);
  localparam logic [IDX_W-1:0] LAST_TAP  = IDX_W'(NTAPS);
  localparam logic [3:0]       MAX_ADDR  = 4'(NTAPS);

  typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

  state_t                    state, state_nxt;
  logic [IDX_W-1:0]          wr_idx;
  logic [IDX_W-1:0]          k;
  logic                      pending;
  logic signed [DATA_W-1:0]  cap  [FRAME_LEN];
  logic signed [DATA_W-1:0]  comp [FRAME_LEN];
  logic signed [COEF_W-1:0]  w    [NTAPS+1];
  logic signed [ACC_W-1:0]   acc;
  logic signed [ACC_W-1:0]   acc_nxt;
  logic signed [PROD_W-1:0]  prod;
  logic                      accept, can_xfer, xfer, frame_done, coef_ok;

  // Power-on coefficient set; index 0 is unused and never weighted.
  function automatic logic signed [COEF_W-1:0] coef_init(input int i);
    case (i)
      1:       return COEF_W'(-95003);
      2:       return COEF_W'(-117939);
      3:       return COEF_W'(52036);
      4:       return COEF_W'(-55799);
      5:       return COEF_W'(-37860);
      6:       return COEF_W'(224943);
      7:       return COEF_W'(150578);
      8:       return COEF_W'(247485);
      9:       return COEF_W'(611424);
      default: return '0;
    endcase
  endfunction

  // Plain bit-slice: dropping the low bits of a two's-complement value
  // rounds toward minus infinity.
  function automatic logic signed [OUT_W-1:0] trunc_out(input logic signed [ACC_W-1:0] a);
    return a[OUT_LSB +: OUT_W];
  endfunction

  assign busy     = (state != IDLE);
  assign out_sig  = (state == OUT);
  assign can_xfer = (state == IDLE) || (state == OUT);
  assign xfer     = pending && can_xfer;
  // A waiting frame only blocks slot 0 when it cannot be handed off this
  // edge; otherwise the hand-off and the new slot-0 write share the edge.
  assign sig_ready  = !(pending && (wr_idx == '0) && !can_xfer);
  assign accept     = sig_valid && sig_ready;
  assign frame_done = accept && (wr_idx == LAST_SLOT);
  assign coef_ok    = coef_we && !busy && (coef_addr != 4'd0) && (coef_addr <= MAX_ADDR);

  // Single shared multiplier, indexed by the current tap.
  assign prod    = PROD_W'(comp[k]) * PROD_W'(w[k]);
  assign acc_nxt = acc + ACC_W'(prod);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (xfer) state_nxt = MAC;
      MAC:     if (k == LAST_TAP) state_nxt = OUT;
      OUT:     state_nxt = xfer ? MAC : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Capture stage: incoming samples fill the frame buffer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_idx  <= '0;
      pending <= 1'b0;
      for (int i = 0; i < FRAME_LEN; i++) cap[i] <= '0;
    end else begin
      if (accept) begin
        cap[wr_idx] <= sig;
        wr_idx      <= (wr_idx == LAST_SLOT) ? '0 : wr_idx + 1'b1;
      end
      if (frame_done) pending <= 1'b1;
      else if (xfer)  pending <= 1'b0;
    end
  end

  // Coefficient store: writes only land while the MAC is idle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      coef_err <= 1'b0;
      for (int i = 0; i <= NTAPS; i++) w[i] <= coef_init(i);
    end else begin
      coef_err <= coef_we && !coef_ok;
      if (coef_ok) w[coef_addr] <= coef_data;
    end
  end

  // Compute stage: frame hand-off, per-tap accumulate, result slice.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      k          <= '0;
      acc        <= '0;
      filter_out <= '0;
      for (int i = 0; i < FRAME_LEN; i++) comp[i] <= '0;
    end else if (xfer) begin
      comp <= cap;
      k    <= IDX_W'(1);
      acc  <= '0;
    end else if (state == MAC) begin
      acc <= acc_nxt;
      k   <= k + 1'b1;
      if (k == LAST_TAP) filter_out <= trunc_out(acc_nxt);
    end
  end

endmodule
